// File: rtl/z80_uart_pkg.sv
// Register map, STATUS/CTRL bit positions and FSM encodings for the Z80 UART.
// Shared by the controller top and the bench.
package z80_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RXLVL  = 2'd3;

    localparam int ST_RX_NE   = 0;
    localparam int ST_RX_OVR  = 1;
    localparam int ST_TX_NF   = 2;
    localparam int ST_TX_IDLE = 3;
    localparam int ST_TX_OVF  = 4;

    localparam int CT_RX_IE  = 0;
    localparam int CT_TXE_IE = 1;
    localparam int CT_FLUSH  = 7;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_CLR  = 1'b1;
    localparam logic [0:0] T_IDLE = 1'b0;
    localparam logic [0:0] T_BUSY = 1'b1;

    function automatic logic [7:0] pack_status(
        input logic rx_ne,
        input logic rx_ovr,
        input logic tx_nf,
        input logic tx_idle,
        input logic tx_ovf
    );
        logic [7:0] s;
        s             = 8'h00;
        s[ST_RX_NE]   = rx_ne;
        s[ST_RX_OVR]  = rx_ovr;
        s[ST_TX_NF]   = tx_nf;
        s[ST_TX_IDLE] = tx_idle;
        s[ST_TX_OVF]  = tx_ovf;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush; push/pop take effect next edge.
// Push while full is accepted only alongside a pop; pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/z80_uart_fifo.sv
// Z80 I/O-mapped UART front end with RX/TX FIFOs and maskable interrupts; bus actions land 3 clk after strobe release.
// No backpressure on the Z80: TX writes to a full FIFO and RX bytes into a full FIFO are dropped and flagged sticky.
module z80_uart_fifo #(
    parameter logic [7:0] IOADDR_BASE  = 8'h00,
    parameter int         RX_DEPTH     = 16,
    parameter int         TX_DEPTH     = 16,
    parameter logic [7:0] IVECTOR      = 8'h6C,
    parameter int         RX_INT_LEVEL = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    input  logic [7:0] a,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       int_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    output logic       rx_clear,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_ready
);

    import z80_uart_pkg::*;

    localparam int RCW = $clog2(RX_DEPTH) + 1;
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam logic [RCW-1:0] RX_LVL_C = RCW'(RX_INT_LEVEL);

    logic [1:0]     iorq_sq, rd_sq, wr_sq, m1_sq;
    logic           addr_hit, sel_s, rd_act, wr_act;
    logic           rd_act_q, wr_act_q, rd_fire, wr_fire;
    logic [1:0]     adr_q;
    logic [7:0]     dat_q;
    logic           rx_pop, sts_clr, tx_wr, ctrl_wr, flush;
    logic           rx_take, rx_push, rx_drop;
    logic           tx_pop, tx_push, tx_drop, tx_idle;
    logic [7:0]     rx_head, tx_head;
    logic [RCW-1:0] rx_count;
    logic [TCW-1:0] tx_count;
    logic           rx_full, rx_empty, tx_full, tx_empty;
    logic [0:0]     rx_st, tx_st;
    logic           rx_ie, txe_ie, rx_ovr, tx_ovf;
    logic [7:0]     status;
    logic [RCW+7:0] rx_lvl_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iorq_sq <= 2'b11;
            rd_sq   <= 2'b11;
            wr_sq   <= 2'b11;
            m1_sq   <= 2'b11;
        end else begin
            iorq_sq <= {iorq_sq[0], iorq_n};
            rd_sq   <= {rd_sq[0], rd_n};
            wr_sq   <= {wr_sq[0], wr_n};
            m1_sq   <= {m1_sq[0], m1_n};
        end
    end

    // m1 must be high: interrupt acknowledge cycles never touch registers.
    assign addr_hit = (a[7:2] == IOADDR_BASE[7:2]);
    assign sel_s    = ~iorq_sq[1] & m1_sq[1] & addr_hit;
    assign rd_act   = sel_s & ~rd_sq[1];
    assign wr_act   = sel_s & ~wr_sq[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_act_q <= 1'b0;
            wr_act_q <= 1'b0;
            adr_q    <= 2'b00;
            dat_q    <= 8'h00;
        end else begin
            rd_act_q <= rd_act;
            wr_act_q <= wr_act;
            if (rd_act || wr_act) begin
                adr_q <= a[1:0];
            end
            if (wr_act) begin
                dat_q <= d_in;
            end
        end
    end

    // Act on the trailing edge so the address/data captured last are used.
    assign rd_fire = rd_act_q & ~rd_act;
    assign wr_fire = wr_act_q & ~wr_act;
    assign rx_pop  = rd_fire & (adr_q == REG_DATA);
    assign sts_clr = rd_fire & (adr_q == REG_STATUS);
    assign tx_wr   = wr_fire & (adr_q == REG_DATA);
    assign ctrl_wr = wr_fire & (adr_q == REG_CTRL);
    assign flush   = ctrl_wr & dat_q[CT_FLUSH];

    assign rx_take = (rx_st == R_IDLE) & rx_data_ready;
    assign rx_push = rx_take & ~flush;
    assign rx_drop = rx_take & rx_full & ~rx_pop;
    assign tx_pop  = (tx_st == T_IDLE) & ~tx_empty & tx_ready;
    assign tx_push = tx_wr & ~flush;
    assign tx_drop = tx_wr & tx_full & ~tx_pop;
    assign tx_idle = (tx_count == '0) & (tx_st == T_IDLE);

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .push     (rx_push),
        .push_dat (rx_data),
        .pop      (rx_pop),
        .head     (rx_head),
        .count    (rx_count),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .push     (tx_push),
        .push_dat (dat_q),
        .pop      (tx_pop),
        .head     (tx_head),
        .count    (tx_count),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_st    <= R_IDLE;
            rx_clear <= 1'b0;
        end else begin
            case (rx_st)
                R_IDLE: if (rx_data_ready) begin
                    rx_clear <= 1'b1;
                    rx_st    <= R_CLR;
                end
                default: if (!rx_data_ready) begin
                    rx_clear <= 1'b0;
                    rx_st    <= R_IDLE;
                end
            endcase
        end
    end

    // A flush leaves an already-launched byte alone; the handshake finishes normally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_st   <= T_IDLE;
            tx_data <= 8'h00;
            tx_send <= 1'b0;
        end else begin
            case (tx_st)
                T_IDLE: if (tx_pop) begin
                    tx_data <= tx_head;
                    tx_send <= 1'b1;
                    tx_st   <= T_BUSY;
                end
                default: if (!tx_ready) begin
                    tx_send <= 1'b0;
                    tx_st   <= T_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ie  <= 1'b1;
            txe_ie <= 1'b0;
            rx_ovr <= 1'b0;
            tx_ovf <= 1'b0;
            int_n  <= 1'b1;
        end else begin
            if (ctrl_wr) begin
                rx_ie  <= dat_q[CT_RX_IE];
                txe_ie <= dat_q[CT_TXE_IE];
            end
            if (flush)        rx_ovr <= 1'b0;
            else if (rx_drop) rx_ovr <= 1'b1;
            else if (sts_clr) rx_ovr <= 1'b0;
            if (flush)        tx_ovf <= 1'b0;
            else if (tx_drop) tx_ovf <= 1'b1;
            else if (sts_clr) tx_ovf <= 1'b0;
            int_n <= ~((rx_ie & (rx_count >= RX_LVL_C)) | (txe_ie & tx_idle));
        end
    end

    assign status   = pack_status(~rx_empty, rx_ovr, ~tx_full, tx_idle, tx_ovf);
    assign rx_lvl_w = {8'h00, rx_count};
    assign d_oe     = (~iorq_n & ~m1_n) | (~iorq_n & ~rd_n & addr_hit);

    always_comb begin
        d_out = 8'h00;
        if (!iorq_n && !m1_n) begin
            d_out = IVECTOR;
        end else if (!iorq_n && !rd_n && addr_hit) begin
            case (a[1:0])
                REG_DATA:   d_out = rx_empty ? 8'h00 : rx_head;
                REG_STATUS: d_out = status;
                REG_CTRL:   d_out = {6'b0, txe_ie, rx_ie};
                default:    d_out = rx_lvl_w[7:0];
            endcase
        end
    end

endmodule

// File: tb/tb_z80_uart_fifo.sv
// Directed bench for z80_uart_fifo: Z80 bus tasks, uart_rx/uart_tx handshake models, queue scoreboards.
module tb_z80_uart_fifo;

    localparam logic [7:0] BASE = 8'h80;
    localparam int         RXD  = 16;
    localparam int         TXD  = 16;

    logic       clk = 1'b0;
    logic       reset_n, iorq_n, rd_n, wr_n, m1_n;
    logic [7:0] a, d_in, d_out, rx_data, tx_data;
    logic       d_oe, int_n, rx_data_ready, rx_clear, tx_send, tx_ready;

    int         n_chk = 0;
    int         n_pass = 0;
    int         n_sends = 0;
    int         tx_mode = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    always #5 clk = ~clk;

    z80_uart_fifo #(
        .IOADDR_BASE  (BASE),
        .RX_DEPTH     (RXD),
        .TX_DEPTH     (TXD),
        .IVECTOR      (8'h6C),
        .RX_INT_LEVEL (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .iorq_n        (iorq_n),
        .rd_n          (rd_n),
        .wr_n          (wr_n),
        .m1_n          (m1_n),
        .a             (a),
        .d_in          (d_in),
        .d_out         (d_out),
        .d_oe          (d_oe),
        .int_n         (int_n),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .rx_clear      (rx_clear),
        .tx_data       (tx_data),
        .tx_send       (tx_send),
        .tx_ready      (tx_ready)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One Z80 I/O cycle; optionally presents an RX byte so it lands on the same edge as the bus action.
    task automatic bus(input logic wr, input logic [7:0] adr, input logic [7:0] dat,
                       input logic inj, input logic [7:0] rb,
                       output logic [7:0] rdat, output logic oe);
        @(posedge clk); #1;
        a = adr; d_in = dat; iorq_n = 1'b0;
        if (wr) wr_n = 1'b0; else rd_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rdat = d_out; oe = d_oe;
        @(posedge clk); #1;
        iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        if (inj) begin
            rx_data = rb; rx_data_ready = 1'b1;
        end
        @(posedge clk); #1;
        if (inj) begin
            check("inj_rx_clear_rise", 8'(rx_clear), 8'h01);
            rx_data_ready = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic io_wr(input logic [1:0] off, input logic [7:0] dat);
        logic [7:0] r;
        logic       o;
        bus(1'b1, BASE | {6'b0, off}, dat, 1'b0, 8'h00, r, o);
    endtask

    task automatic io_rd(input logic [1:0] off, output logic [7:0] r);
        logic o;
        bus(1'b0, BASE | {6'b0, off}, 8'h00, 1'b0, 8'h00, r, o);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_data_ready = 1'b1;
        @(posedge clk); #1;
        check("rx_clear_rise", 8'(rx_clear), 8'h01);
        rx_data_ready = 1'b0;
        @(posedge clk); #1;
        check("rx_clear_fall", 8'(rx_clear), 8'h00);
    endtask

    // uart_tx model: mode 0 consumes bytes, 1 holds tx_ready low, 2 holds it high without consuming.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tx_mode == 1) begin
                tx_ready = 1'b0;
            end else if (tx_mode == 2) begin
                tx_ready = 1'b1;
            end else if (tx_send && tx_ready) begin
                check("tx_expected", 8'(txq.size() > 0), 8'h01);
                if (txq.size() > 0) check("tx_data", tx_data, txq.pop_front());
                n_sends++;
                tx_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                tx_ready = 1'b1;
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    initial begin
        logic [7:0] r;
        logic       o;
        logic [7:0] b;
        reset_n = 1'b0; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        a = 8'h00; d_in = 8'h00; rx_data = 8'h00; rx_data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_send", 8'(tx_send), 8'h00);
        check("rst_rx_clear", 8'(rx_clear), 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_int_n", 8'(int_n), 8'h01);
        check("rst_d_out", d_out, 8'h00);
        check("rst_d_oe", 8'(d_oe), 8'h00);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        io_rd(2'd1, r); check("init_status", r, 8'h0C);
        io_rd(2'd2, r); check("init_ctrl", r, 8'h01);
        io_rd(2'd3, r); check("init_rxlvl", r, 8'h00);

        // TX string through the uart_tx model
        for (int i = 0; i < 3; i++) begin
            b = 8'h41 + 8'(i);
            txq.push_back(b);
            io_wr(2'd0, b);
        end
        for (int k = 0; k < 300 && n_sends < 3; k++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        check("tx_send_count", 8'(n_sends), 8'h03);
        check("tx_queue_drained", 8'(txq.size()), 8'h00);
        io_rd(2'd1, r); check("tx_done_status", r, 8'h0C);

        // TX overflow with tx_ready held low, one RX byte pending
        rx_byte(8'h55);
        tx_mode = 1;
        repeat (2) @(posedge clk);
        for (int i = 0; i <= TXD; i++) io_wr(2'd0, 8'(i));
        io_rd(2'd1, r); check("ovf_status", r, 8'h11);
        io_rd(2'd1, r); check("ovf_status_cleared", r, 8'h01);
        io_rd(2'd3, r); check("ovf_rxlvl", r, 8'h01);
        io_wr(2'd2, 8'h81);
        io_rd(2'd3, r); check("flush_rxlvl", r, 8'h00);
        io_rd(2'd1, r); check("flush_status", r, 8'h0C);
        tx_mode = 0;
        repeat (10) @(posedge clk);
        #1;
        check("flush_no_tx", 8'(n_sends), 8'h03);

        // RX fill past capacity, then drain
        for (int i = 0; i < RXD + 2; i++) begin
            b = 8'hA0 + 8'(i);
            if (i < RXD) rxq.push_back(b);
            rx_byte(b);
        end
        io_rd(2'd3, r); check("fill_rxlvl", r, 8'(RXD));
        io_rd(2'd1, r); check("fill_status", r, 8'h0F);
        for (int i = 0; i < RXD; i++) begin
            io_rd(2'd0, r); check("drain_data", r, rxq.pop_front());
        end
        io_rd(2'd0, r); check("empty_data_read", r, 8'h00);
        io_rd(2'd3, r); check("drain_rxlvl", r, 8'h00);

        // RX push on the same edge as a DATA pop of a full FIFO
        for (int i = 0; i < RXD; i++) begin
            b = 8'hB0 + 8'(i);
            rxq.push_back(b);
            rx_byte(b);
        end
        bus(1'b0, BASE, 8'h00, 1'b1, 8'hC0, r, o);
        check("simul_pop_data", r, rxq.pop_front());
        rxq.push_back(8'hC0);
        io_rd(2'd3, r); check("simul_rxlvl", r, 8'(RXD));
        io_rd(2'd1, r); check("simul_status", r, 8'h0D);
        for (int i = 0; i < RXD; i++) begin
            io_rd(2'd0, r); check("simul_drain", r, rxq.pop_front());
        end

        // Flush on the same edge as an RX push, with TX bytes queued
        tx_mode = 1;
        io_wr(2'd0, 8'h99);
        io_wr(2'd0, 8'h9A);
        rx_byte(8'hD0);
        bus(1'b1, BASE | 8'h02, 8'h81, 1'b1, 8'hD1, r, o);
        io_rd(2'd3, r); check("flush_push_rxlvl", r, 8'h00);
        io_rd(2'd1, r); check("flush_push_status", r, 8'h0C);
        tx_mode = 0;
        repeat (10) @(posedge clk);
        #1;
        check("flush_push_no_tx", 8'(n_sends), 8'h03);

        // Interrupts and acknowledge
        check("int_idle", 8'(int_n), 8'h01);
        rx_byte(8'h3C);
        check("int_rx", 8'(int_n), 8'h00);
        @(posedge clk); #1;
        a = 8'h00; iorq_n = 1'b0; m1_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("inta_d_out", d_out, 8'h6C);
        check("inta_d_oe", 8'(d_oe), 8'h01);
        iorq_n = 1'b1; m1_n = 1'b1;
        repeat (4) @(posedge clk);
        io_rd(2'd0, r); check("int_data", r, 8'h3C);
        check("int_cleared", 8'(int_n), 8'h01);
        io_wr(2'd2, 8'h02);
        check("int_txe", 8'(int_n), 8'h00);
        io_rd(2'd2, r); check("ctrl_txe", r, 8'h02);
        io_wr(2'd2, 8'h01);
        check("int_txe_off", 8'(int_n), 8'h01);

        // Reset in the middle of a TX handshake
        tx_mode = 2;
        repeat (2) @(posedge clk);
        io_wr(2'd0, 8'h5A);
        check("busy_tx_send", 8'(tx_send), 8'h01);
        rx_byte(8'h77);
        check("busy_int_n", 8'(int_n), 8'h00);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("midrst_tx_send", 8'(tx_send), 8'h00);
        check("midrst_int_n", 8'(int_n), 8'h01);
        a = BASE | 8'h01; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        check("midrst_status", d_out, 8'h0C);
        check("midrst_d_oe", 8'(d_oe), 8'h01);
        #1;
        iorq_n = 1'b1; rd_n = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        tx_mode = 0;
        repeat (4) @(posedge clk);
        io_rd(2'd3, r); check("post_rst_rxlvl", r, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
